// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants (also used by the ALU), fetch FSM
// states and the instruction length type.
package cpu_pkg;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    // One-byte instructions
    localparam logic [7:0] OPC_PUSH_EBX  = 8'h53;
    localparam logic [7:0] OPC_PUSH_EBP  = 8'h55;
    localparam logic [7:0] OPC_POP_EBP   = 8'h5d;
    localparam logic [7:0] OPC_RET       = 8'hc3;
    localparam logic [7:0] OPC_LEAVE     = 8'hc9;
    // Two-byte instructions
    localparam logic [7:0] OPC_PUSH_IMM8 = 8'h6a;
    localparam logic [7:0] OPC_JNE       = 8'h75;
    localparam logic [7:0] OPC_JMP       = 8'heb;
    localparam logic [7:0] OPC_MOV_RM_R  = 8'h89;
    // Five-byte instructions
    localparam logic [7:0] OPC_MOV_IMM   = 8'hb8;
    localparam logic [7:0] OPC_CALL      = 8'he8;
    // Length depends on the ModR/M mod field
    localparam logic [7:0] OPC_MOV_R_RM  = 8'h8b;
    localparam logic [7:0] OPC_GRP1_IMM8 = 8'h83;

    typedef logic [3:0] len_t;

    typedef enum logic [1:0] {
        S_REQ,
        S_BYTE,
        S_HOLD
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_align_if.sv
// Fetch-stage bus: instruction memory read port, execute-stage handshake and
// control-flow redirect.
interface inst_fetch_align_if;
    import cpu_pkg::*;

    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [31:0] ope;
    len_t        num_of_ope;
    logic [31:0] ope_eip;
    logic        illegal;
    logic        ope_valid;
    logic        ope_ready;
    logic        redirect;
    logic [31:0] redirect_addr;

    modport master (
        output mem_addr, mem_rd, ope, num_of_ope, ope_eip, illegal, ope_valid,
        input  mem_rdata, ope_ready, redirect, redirect_addr
    );

    modport slave (
        input  mem_addr, mem_rd, ope, num_of_ope, ope_eip, illegal, ope_valid,
        output mem_rdata, ope_ready, redirect, redirect_addr
    );

endinterface

// File: rtl/inst_len_decode.sv
// Combinational instruction length / legality decoder.
module inst_len_decode
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [7:0] modrm,
    input  logic       have_modrm,
    output len_t       len,
    output logic       need_modrm,
    output logic       illegal
);

    // Only the mod field affects length.
    logic unused_modrm_low;
    assign unused_modrm_low = ^modrm[5:0];

    // Map opcode (plus mod field once available) to length and legality.
    always_comb begin
        len        = 4'd1;
        need_modrm = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OPC_PUSH_EBP, OPC_PUSH_EBX, OPC_POP_EBP, OPC_RET, OPC_LEAVE: len = 4'd1;
            OPC_PUSH_IMM8, OPC_JNE, OPC_JMP, OPC_MOV_RM_R:                len = 4'd2;
            OPC_MOV_IMM, OPC_CALL:                                        len = 4'd5;
            OPC_MOV_R_RM, OPC_GRP1_IMM8: begin
                if (!have_modrm) begin
                    need_modrm = 1'b1;
                    len        = 4'd2;
                end else begin
                    case (modrm[7:6])
                        2'b11:   len = (opcode == OPC_GRP1_IMM8) ? 4'd3 : 4'd2;
                        2'b01:   len = (opcode == OPC_GRP1_IMM8) ? 4'd4 : 4'd3;
                        default: begin
                            len     = 4'd2;
                            illegal = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                len     = 4'd1;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_fetch_align.sv
// Byte-serial instruction fetch and alignment: reads one byte per cycle,
// decodes length on the fly and presents a packed 32-bit window.
module inst_fetch_align
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
    input logic                clock,
    input logic                reset,
    inst_fetch_align_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [2:0]   k_q, k_d;
    logic [31:0]  fetch_eip_q, fetch_eip_d;
    logic [31:0]  ope_q, ope_d;
    logic [31:0]  ope_eip_q, ope_eip_d;
    len_t         num_q, num_d;
    logic         illegal_q, illegal_d;

    logic [7:0]   dec_opcode;
    logic [7:0]   dec_modrm;
    logic         dec_have_modrm;
    len_t         dec_len;
    logic         dec_need_modrm;
    logic         dec_illegal;

    logic [2:0]   k_inc;
    logic         more;
    logic         rd_issue;
    logic [31:0]  rd_addr;

    // The byte arriving this cycle stands in for its not-yet-written slot.
    always_comb begin
        dec_opcode     = (k_q == 3'd0) ? bus.mem_rdata : ope_q[31:24];
        dec_modrm      = (k_q == 3'd1) ? bus.mem_rdata : ope_q[23:16];
        dec_have_modrm = (k_q != 3'd0);
    end

    inst_len_decode u_len_decode (
        .opcode     (dec_opcode),
        .modrm      (dec_modrm),
        .have_modrm (dec_have_modrm),
        .len        (dec_len),
        .need_modrm (dec_need_modrm),
        .illegal    (dec_illegal)
    );

    assign k_inc = k_q + 3'd1;
    assign more  = dec_need_modrm || (({1'b0, k_q} + 4'd1) < dec_len);

    // FSM next state, window assembly, read issue and redirect override.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        fetch_eip_d = fetch_eip_q;
        ope_d       = ope_q;
        ope_eip_d   = ope_eip_q;
        num_d       = num_q;
        illegal_d   = illegal_q;
        rd_issue    = 1'b0;
        rd_addr     = fetch_eip_q;

        case (state_q)
            S_REQ: begin
                rd_issue  = 1'b1;
                rd_addr   = fetch_eip_q;
                ope_eip_d = fetch_eip_q;
                k_d       = 3'd0;
                state_d   = S_BYTE;
            end
            S_BYTE: begin
                // Byte 4 of a 5-byte instruction has no slot and is dropped.
                case (k_q)
                    3'd0:    ope_d[31:24] = bus.mem_rdata;
                    3'd1:    ope_d[23:16] = bus.mem_rdata;
                    3'd2:    ope_d[15:8]  = bus.mem_rdata;
                    3'd3:    ope_d[7:0]   = bus.mem_rdata;
                    default: ;
                endcase
                if (more) begin
                    rd_issue = 1'b1;
                    rd_addr  = ope_eip_q + {29'd0, k_inc};
                    k_d      = k_inc;
                end else begin
                    num_d     = dec_len;
                    illegal_d = dec_illegal;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.ope_ready) begin
                    fetch_eip_d = ope_eip_q + {28'd0, num_q};
                    ope_d       = '0;
                    num_d       = '0;
                    illegal_d   = 1'b0;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect beats everything, including a same-cycle handshake.
        if (bus.redirect) begin
            fetch_eip_d = bus.redirect_addr;
            ope_d       = '0;
            num_d       = '0;
            illegal_d   = 1'b0;
            k_d         = 3'd0;
            rd_issue    = 1'b0;
            state_d     = S_REQ;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_REQ;
            k_q         <= 3'd0;
            fetch_eip_q <= RESET_ADDR;
            ope_q       <= '0;
            ope_eip_q   <= '0;
            num_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            fetch_eip_q <= fetch_eip_d;
            ope_q       <= ope_d;
            ope_eip_q   <= ope_eip_d;
            num_q       <= num_d;
            illegal_q   <= illegal_d;
        end
    end

    // Read strobe is masked by reset so it is low the instant reset asserts.
    assign bus.mem_rd     = rd_issue & ~reset;
    assign bus.mem_addr   = rd_addr;
    assign bus.ope        = ope_q;
    assign bus.num_of_ope = num_q;
    assign bus.ope_eip    = ope_eip_q;
    assign bus.illegal    = illegal_q;
    assign bus.ope_valid  = (state_q == S_HOLD);

endmodule

// File: tb/tb_inst_fetch_align.sv
// Bench for inst_fetch_align: directed literal scenarios plus a randomized run,
// with a per-cycle compare against a byte-stream reference model.
module tb_inst_fetch_align;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset;

    inst_fetch_align_if bus ();

    inst_fetch_align dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [logic [31:0]];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h90;
    endfunction

    // Reference length table.
    function automatic int ref_len(input logic [7:0] op, input logic [7:0] m);
        if (op inside {8'h55, 8'h53, 8'h5d, 8'hc3, 8'hc9}) return 1;
        if (op inside {8'h6a, 8'h75, 8'heb, 8'h89}) return 2;
        if (op inside {8'hb8, 8'he8}) return 5;
        if (op == 8'h8b) return (m[7:6] == 2'b11) ? 2 : (m[7:6] == 2'b01) ? 3 : 2;
        if (op == 8'h83) return (m[7:6] == 2'b11) ? 3 : (m[7:6] == 2'b01) ? 4 : 2;
        return 1;
    endfunction

    function automatic bit ref_illegal(input logic [7:0] op, input logic [7:0] m);
        if (op inside {8'h55, 8'h53, 8'h5d, 8'hc3, 8'hc9, 8'h6a, 8'h75, 8'heb, 8'h89,
                       8'hb8, 8'he8}) return 1'b0;
        if (op == 8'h8b || op == 8'h83) return !(m[7:6] == 2'b11 || m[7:6] == 2'b01);
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_window(input logic [31:0] eip);
        int n;
        logic [31:0] w;
        n = ref_len(rd_mem(eip), rd_mem(eip + 32'd1));
        w = '0;
        for (int i = 0; i < 4; i++)
            if (i < n) w[31 - 8 * i -: 8] = rd_mem(eip + 32'(i));
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Synchronous byte memory.
    always @(posedge clock)
        if (bus.mem_rd) bus.mem_rdata <= rd_mem(bus.mem_addr);

    // ---------------- reference model / compare process ----------------
    logic [31:0] m_eip = RESET_ADDR;
    logic [31:0] log_addr[$];
    int          log_cyc[$];
    int          cyc = 0;
    bit          prev_valid = 1'b0;
    bit          hs_pend = 1'b0;
    int          hs_cyc = 0;
    int          n_insn = 0;
    int          e_len;
    logic [7:0]  e_op, e_m;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            m_eip = RESET_ADDR;
            log_addr.delete();
            log_cyc.delete();
            prev_valid = 1'b0;
            hs_pend    = 1'b0;
        end else begin
            e_op  = rd_mem(m_eip);
            e_m   = rd_mem(m_eip + 32'd1);
            e_len = ref_len(e_op, e_m);
            if (bus.ope_valid) begin
                check("ope", bus.ope, ref_window(m_eip));
                check("num_of_ope", 32'(bus.num_of_ope), 32'(e_len));
                check("ope_eip", bus.ope_eip, m_eip);
                check("illegal", 32'(bus.illegal), 32'(ref_illegal(e_op, e_m)));
                check("no_read_while_valid", 32'(bus.mem_rd), 32'd0);
                if (!prev_valid) begin
                    n_insn++;
                    check("read_count", 32'(log_addr.size()), 32'(e_len));
                    for (int i = 0; i < log_addr.size(); i++)
                        check("read_addr", log_addr[i], m_eip + 32'(i));
                    if (log_cyc.size() > 0)
                        check("latency", 32'(cyc - log_cyc[0]), 32'(e_len + 1));
                end
            end
            if (bus.mem_rd && !bus.redirect) begin
                if (log_addr.size() == 0 && hs_pend) begin
                    check("throughput", 32'(cyc - hs_cyc), 32'd1);
                    hs_pend = 1'b0;
                end
                log_addr.push_back(bus.mem_addr);
                log_cyc.push_back(cyc);
            end
            if (bus.redirect) begin
                m_eip = bus.redirect_addr;
                log_addr.delete();
                log_cyc.delete();
                hs_pend = 1'b0;
            end else if (bus.ope_valid && bus.ope_ready) begin
                m_eip = m_eip + 32'(e_len);
                log_addr.delete();
                log_cyc.delete();
                hs_pend = 1'b1;
                hs_cyc  = cyc;
            end
            prev_valid = bus.ope_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.ope_valid && n < 40) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(bus.ope_valid), 32'd1);
    endtask

    task automatic next_insn(output int n);
        tick();
        wait_valid(n);
    endtask

    task automatic wait_read(input logic [31:0] a);
        int g = 0;
        while (!(bus.mem_rd && bus.mem_addr == a) && g < 10) begin
            tick();
            g++;
        end
        check("wait_read", bus.mem_addr, a);
    endtask

    task automatic check_outputs_reset();
        check("rst_ope", bus.ope, 32'd0);
        check("rst_num", 32'(bus.num_of_ope), 32'd0);
        check("rst_eip", bus.ope_eip, 32'd0);
        check("rst_illegal", 32'(bus.illegal), 32'd0);
        check("rst_valid", 32'(bus.ope_valid), 32'd0);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_mem_addr", bus.mem_addr, RESET_ADDR);
    endtask

    task automatic load(input logic [31:0] a, input logic [7:0] b []);
        foreach (b[i]) mem[a + 32'(i)] = b[i];
    endtask

    logic [7:0] ops [13] = '{8'h55, 8'h53, 8'h5d, 8'hc3, 8'hc9, 8'h6a, 8'h75, 8'heb,
                             8'h89, 8'hb8, 8'he8, 8'h8b, 8'h83};

    initial begin
        int n;
        reset             = 1'b1;
        bus.ope_ready     = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;

        load(32'h00, '{8'h55, 8'h0f, 8'h6a, 8'h03});
        load(32'h10, '{8'hb8, 8'h05, 8'h00, 8'h00, 8'h00});
        load(32'h15, '{8'h83, 8'h7d, 8'hfc, 8'h00});
        load(32'h19, '{8'h8b, 8'h45, 8'h08});
        load(32'h1c, '{8'h8b, 8'hec});
        load(32'h1e, '{8'he8, 8'h11, 8'h22, 8'h33, 8'h44});
        load(32'h40, '{8'h89, 8'he5, 8'hc3});
        load(32'h50, '{8'heb, 8'hfe, 8'h8b, 8'h00});
        load(32'h54, '{8'hb8, 8'h01, 8'h02, 8'h03, 8'h04});
        load(32'hffff_fffe, '{8'h6a, 8'h7f});
        for (int a = 0; a < 'h800; a++)
            mem[32'h1000 + 32'(a)] = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                                : ops[$urandom_range(0, 12)];

        // Pin the reference table.
        check("model_len_837d", 32'(ref_len(8'h83, 8'h7d)), 32'd4);
        check("model_len_8b45", 32'(ref_len(8'h8b, 8'h45)), 32'd3);
        check("model_len_e8", 32'(ref_len(8'he8, 8'h00)), 32'd5);
        check("model_ill_8b00", 32'(ref_illegal(8'h8b, 8'h00)), 32'd1);
        check("model_ill_0f", 32'(ref_illegal(8'h0f, 8'h00)), 32'd1);

        repeat (3) tick();
        check_outputs_reset();

        // 55 at address 0: valid in cycle 2 after release.
        reset = 1'b0;
        #1;
        check("first_read_rd", 32'(bus.mem_rd), 32'd1);
        check("first_read_addr", bus.mem_addr, 32'd0);
        tick();
        check("c1_valid", 32'(bus.ope_valid), 32'd0);
        tick();
        check("c2_valid", 32'(bus.ope_valid), 32'd1);
        check("55_ope", bus.ope, 32'h5500_0000);
        check("55_num", 32'(bus.num_of_ope), 32'd1);
        check("55_eip", bus.ope_eip, 32'd0);
        tick();
        check("after55_addr", bus.mem_addr, 32'd1);
        check("after55_rd", 32'(bus.mem_rd), 32'd1);

        // Illegal opcode 0f.
        wait_valid(n);
        check("0f_ope", bus.ope, 32'h0f00_0000);
        check("0f_illegal", 32'(bus.illegal), 32'd1);
        check("0f_num", 32'(bus.num_of_ope), 32'd1);

        // 6a 03 held with ready low.
        tick();
        bus.ope_ready = 1'b0;
        wait_valid(n);
        check("6a_lat", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 32'(bus.ope_valid), 32'd1);
            check("hold_ope", bus.ope, 32'h6a03_0000);
            check("hold_no_rd", 32'(bus.mem_rd), 32'd0);
        end
        bus.ope_ready = 1'b1;
        tick();
        check("accept_valid", 32'(bus.ope_valid), 32'd0);
        check("accept_next", bus.mem_addr, 32'd4);

        // Redirect to b8 05 00 00 00 at 0x10.
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h10;
        tick();
        bus.redirect = 1'b0;
        wait_valid(n);
        check("b8_lat", 32'(n), 32'd6);
        check("b8_ope", bus.ope, 32'hb805_0000);
        check("b8_num", 32'(bus.num_of_ope), 32'd5);
        next_insn(n);
        check("83_eip", bus.ope_eip, 32'h15);
        check("83_ope", bus.ope, 32'h837d_fc00);
        check("83_num", 32'(bus.num_of_ope), 32'd4);
        next_insn(n);
        check("8b45_ope", bus.ope, 32'h8b45_0800);
        check("8b45_num", 32'(bus.num_of_ope), 32'd3);
        next_insn(n);
        check("8bec_num", 32'(bus.num_of_ope), 32'd2);

        // Redirect during byte 2 of e8.
        tick();
        wait_read(32'h20);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h40;
        tick();
        bus.redirect = 1'b0;
        wait_valid(n);
        check("redir_eip", bus.ope_eip, 32'h40);
        check("redir_ope", bus.ope, 32'h89e5_0000);

        // Redirect in a handshake cycle wins.
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h50;
        tick();
        bus.redirect = 1'b0;
        wait_valid(n);
        check("redir_hs_eip", bus.ope_eip, 32'h50);
        next_insn(n);
        check("8b00_ope", bus.ope, 32'h8b00_0000);
        check("8b00_illegal", 32'(bus.illegal), 32'd1);
        check("8b00_num", 32'(bus.num_of_ope), 32'd2);

        // Asynchronous reset mid-instruction.
        tick();
        wait_read(32'h56);
        reset = 1'b1;
        #1;
        check_outputs_reset();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("restart_addr", bus.mem_addr, RESET_ADDR);
        wait_valid(n);
        check("restart_ope", bus.ope, 32'h5500_0000);

        // Address wrap-around.
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'hffff_fffe;
        tick();
        bus.redirect = 1'b0;
        wait_valid(n);
        check("wrap_ope", bus.ope, 32'h6a7f_0000);
        next_insn(n);
        check("wrap_eip", bus.ope_eip, 32'd0);

        // Randomized run.
        bus.redirect      = 1'b1;
        bus.redirect_addr = 32'h1000;
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bus.ope_ready     = ($urandom_range(0, 99) < 70);
            bus.redirect      = ($urandom_range(0, 99) == 0);
            bus.redirect_addr = 32'h1000 + 32'($urandom_range(0, 'h7ff));
            tick();
        end
        bus.redirect  = 1'b0;
        bus.ope_ready = 1'b1;
        repeat (20) tick();
        check("insn_count", 32'(n_insn > 150), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
